// File: rtl/riscv_pkg.sv
// Shared processor-wide constants and the fetch buffer entry type.
// Every pipeline stage imports this package.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int PC_STEP = 4;

  // Canonical NOP (addi x0, x0, 0), used downstream when a bubble is inserted
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instr} entries.
// It supports flush, simultaneous push/pop, a count output and a combinational head.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // A flush discards every entry, including any pop in the same cycle (that pop is already consumed).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wr_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Pipeline front end: owns the PC, buffers fetched words and hands them to decode.
// It also handles redirects and halts once the PC leaves the populated memory.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2,
  parameter int              MEM_BYTES  = 1001
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  input  logic [ILEN-1:0] instr_code,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            fetch_halt
);

  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN:0] LAST_BYTE = (XLEN + 1)'(MEM_BYTES - 1);

  // Evaluated one bit wider than the PC so an address near 2^32 cannot wrap into range
  function automatic logic in_range_f(input logic [XLEN-1:0] addr);
    return ({1'b0, addr} + (XLEN + 1)'(3)) <= LAST_BYTE;
  endfunction

  logic [XLEN-1:0] r_pc;
  logic            r_halt;
  logic [XLEN-1:0] w_pc_next;
  logic            w_in_range;
  logic            w_pop;
  logic            w_can_push;
  logic            w_push;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_wr_entry;

  assign w_in_range = in_range_f(r_pc);
  assign id_valid   = (w_count != '0);
  assign w_pop      = id_valid & id_ready;
  assign w_can_push = (w_count < CW'(FIFO_DEPTH)) | w_pop;
  assign w_push     = w_in_range & w_can_push & ~redirect_valid;
  assign w_wr_entry = '{pc: r_pc, instr: instr_code};

  always_comb begin
    w_pc_next = r_pc;
    if (redirect_valid) begin
      w_pc_next = redirect_pc & ~XLEN'(3);
    end else if (w_push) begin
      w_pc_next = r_pc + XLEN'(PC_STEP);
    end else begin
      w_pc_next = r_pc;
    end
  end

  // A stalled PC holds, so the same word is simply re-read on the next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc   <= RESET_PC;
      r_halt <= 1'b0;
    end else begin
      r_pc   <= w_pc_next;
      r_halt <= ~in_range_f(w_pc_next);
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (w_push),
    .pop      (w_pop),
    .wr_entry (w_wr_entry),
    .head     (w_head),
    .count    (w_count)
  );

  assign pc         = r_pc;
  assign id_instr   = w_head.instr;
  assign id_pc      = w_head.pc;
  assign fetch_halt = r_halt;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based reference model predicts each cycle's
// outputs, and a negedge monitor compares them against the DUT.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int          MEM_BYTES = 1001;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] W0        = 32'h0050_0093;
  localparam logic [31:0] W1        = 32'h00A0_0113;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        halt;
    logic [31:0] hpc;
    logic [31:0] hinstr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr_code;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        fetch_halt;

  logic [31:0]  mem [256];
  exp_t         exp_q [$];
  fetch_entry_t mq [$];
  logic [31:0]  mpc;
  logic         mhalt;
  exp_t         mon_e;
  int           vectors     = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  assign instr_code = (pc < 32'd1024) ? mem[pc[9:2]] : 32'h0;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH),
    .MEM_BYTES  (MEM_BYTES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .instr_code     (instr_code),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .fetch_halt     (fetch_halt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_mem(input logic [31:0] a);
    return (longint'(a) + 64'sd3) <= longint'(MEM_BYTES - 1);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd1024) ? mem[a[9:2]] : 32'h0;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    mpc   = 32'h0;
    mhalt = 1'b0;
  endtask

  // Drive one cycle: record the expected current state, then advance the model across the edge
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    exp_t         e;
    fetch_entry_t ent;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    e.valid  = (mq.size() != 0);
    e.pc     = mpc;
    e.halt   = mhalt;
    e.hpc    = e.valid ? mq[0].pc : 32'h0;
    e.hinstr = e.valid ? mq[0].instr : 32'h0;
    exp_q.push_back(e);
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (rv) begin
      mq.delete();
      mpc = rpc & 32'hFFFF_FFFC;
    end else if (in_mem(mpc) && mq.size() < DEPTH) begin
      ent.pc    = mpc;
      ent.instr = mem_word(mpc);
      mq.push_back(ent);
      mpc = mpc + 32'd4;
    end
    mhalt = !in_mem(mpc);
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("id_valid", {31'b0, id_valid}, {31'b0, mon_e.valid});
      chk("pc", pc, mon_e.pc);
      chk("fetch_halt", {31'b0, fetch_halt}, {31'b0, mon_e.halt});
      if (mon_e.valid) begin
        chk("id_pc", id_pc, mon_e.hpc);
        chk("id_instr", id_instr, mon_e.hinstr);
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_id_valid"}, {31'b0, id_valid}, 32'h0);
    chk({tag, "_id_pc"}, id_pc, 32'h0);
    chk({tag, "_id_instr"}, id_instr, 32'h0);
    chk({tag, "_halt"}, {31'b0, fetch_halt}, 32'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = W0;
    mem[1] = W1;
    rst = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk_reset_state("reset");
    rst = 1'b1;

    // Start-up stream with decode always ready
    cycle(1'b1, 1'b0, 32'h0);
    chk("first_pc", id_pc, 32'h0);
    chk("first_instr", id_instr, W0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("second_pc", id_pc, 32'h4);
    chk("second_instr", id_instr, W1);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);

    // Back-pressure: fill the buffer, then drain
    repeat (5) cycle(1'b0, 1'b0, 32'h0);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Redirect while the buffer is full
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0042);
    chk("redir_valid", {31'b0, id_valid}, 32'h0);
    chk("redir_pc", pc, 32'h40);
    cycle(1'b1, 1'b0, 32'h0);
    chk("redir_id_pc", id_pc, 32'h40);

    // Run off the end of memory, then recover
    cycle(1'b1, 1'b1, 32'd960);
    repeat (14) cycle(1'b1, 1'b0, 32'h0);
    chk("halt_set", {31'b0, fetch_halt}, 32'h1);
    chk("halt_pc", pc, 32'd1000);
    cycle(1'b1, 1'b1, 32'h0);
    chk("halt_clr", {31'b0, fetch_halt}, 32'h0);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Randomised traffic with occasional redirects, including boundary targets
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFFC;
        1:       tgt = 32'd997;
        default: tgt = $urandom_range(0, 1023);
      endcase
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), tgt);
    end

    // Asynchronous reset between edges
    #1 rst = 1'b0;
    #1 chk_reset_state("async_reset");
    model_reset();
    @(posedge clk);
    #2;
    chk_reset_state("reset_hold");
    rst = 1'b1;
    repeat (30) cycle(($urandom_range(0, 3) != 0), 1'b0, 32'h0);

    #10;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the processor pipeline. Owns the program counter and drives it into the combinational instruction memory.
- Captures the returned 32-bit instruction word and its PC into a small FIFO.
- Presents {instr, pc} to decode with a valid/ready handshake.
- Handles redirects (branch/jump targets) by flushing buffered instructions, and halts fetch when the PC leaves the populated memory range.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, number of buffered {pc, instr} entries; must be a power of two and at least 2.
- MEM_BYTES, 1001, byte size of instruction memory; a fetch is legal only while PC+3 <= MEM_BYTES-1.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- pc, output, 32, fetch address to instruction memory; read data returns combinationally in the same cycle.
- instr_code, input, 32, instruction word from memory for the current pc.
- redirect_valid, input, 1, request to restart fetch at redirect_pc.
- redirect_pc, input, 32, new fetch address; bits [1:0] are ignored and forced to 0.
- id_ready, input, 1, decode can accept an instruction this cycle.
- id_valid, output, 1, the {id_pc, id_instr} output holds a valid entry.
- id_instr, output, 32, instruction at the FIFO head.
- id_pc, output, 32, PC of the instruction at the FIFO head.
- fetch_halt, output, 1, fetch has stopped because pc is out of range.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- While rst=0:
  - pc = RESET_PC.
  - FIFO count = 0; read and write pointers = 0; all entries are cleared to 0.
  - id_valid=0, id_instr=0, id_pc=0, fetch_halt=0.
  - Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Definitions for each cycle:
  - in_range = (pc + 3 <= MEM_BYTES-1), evaluated with 33-bit arithmetic so it cannot wrap.
  - pop = id_valid & id_ready.
  - can_push = (count < FIFO_DEPTH) | pop.
  - push = in_range & can_push & ~redirect_valid.
- Push: write {pc, instr_code} at the write pointer and set pc <= pc + 4. pc wraps modulo 2^32.
- When in_range=1 but the FIFO is full with no pop, pc holds. Stalls are lossless: the instruction at pc is re-read next cycle.
- id_valid = (count != 0). id_instr and id_pc come combinationally from the head entry.
- Push and pop in the same cycle: count is unchanged. This is legal even when the FIFO is full, because the pop frees the slot.
- Redirect (redirect_valid=1):
  - At the next edge, pc <= {redirect_pc[31:2], 2'b00}; count and pointers are cleared; no push occurs.
  - A pop in the same cycle still counts as a completed transfer to decode. All other entries are discarded.
  - The cycle after a redirect, id_valid=0.
  - The first redirected instruction appears at id_valid one cycle after the redirect edge, i.e. 2 edges after redirect_valid is sampled.
- Latency:
  - With an empty FIFO and in_range=1, an instruction fetched at cycle N is visible on id_* after edge N+1.
  - Sustained throughput is one instruction per cycle when id_ready=1.
- Halt:
  - fetch_halt = ~in_range, registered so it is updated at each edge from the next pc.
  - While halted, buffered entries still drain to decode.
  - A redirect to an in-range address clears fetch_halt at the next edge.
- Consecutive redirects: the last sampled redirect wins.
- Misaligned redirect_pc: the low bits are silently dropped; no exception is raised.
- Illegal instruction words are passed through unchanged; decode owns their handling.

Decomposition:
- Shared package (riscv_pkg) holds:
  - XLEN=32;
  - ILEN=32;
  - PC_STEP=4;
  - NOP_INSTR=32'h0000_0013, used by downstream bubble insertion;
  - a fetch_entry_t struct {pc[31:0], instr[31:0]}.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO with flush, push/pop, count, and head outputs.
- The pc register, in_range, and halt logic stay in fetch_unit.

Test Plan:
- Reset release, id_ready=1, memory preloaded with words W0=32'h00500093 at address 0 and W1=32'h00A00113 at address 4 -> pc sequence 0,4,8,... one step per cycle; id_valid=1 from the first edge after reset; id_pc/id_instr = 0/W0, then 4/W1.
- id_ready=0 for 5 cycles -> FIFO fills to 2 entries (pc 0 and 4); pc holds at 8; no entries are lost. On release, entries drain in order 0, 4, 8.
- Full FIFO with id_ready=1 -> push and pop occur in the same cycle; count stays 2; pc advances by 4 each cycle.
- redirect_valid=1 with redirect_pc=32'h0000_0042 while 2 entries are buffered -> next cycle pc=32'h40, id_valid=0; the following cycle id_pc=32'h40.
- Sequential fetch reaching pc=32'd1000 with MEM_BYTES=1001 -> the instruction at pc=996 is delivered; fetch_halt=1; pc holds at 1000. A redirect to 32'h0 then clears fetch_halt and fetch resumes.
- Assert rst=0 asynchronously between clock edges mid-stream -> id_valid=0, pc=RESET_PC, and fetch_halt=0 immediately, before the next edge.
